// File: rtl/alsu_pkg.sv
// alsu_pkg: shared width, FSM state type and op-group encodings for the ALSU accumulator controller
package alsu_pkg;
  localparam int W = 8;
  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
  localparam logic [1:0] ARITH = 2'b00;
  localparam logic [1:0] LOGIC = 2'b01;
  localparam logic [1:0] SHR   = 2'b10;
  localparam logic [1:0] SHL   = 2'b11;
endpackage

// File: rtl/alsu_flag_gen.sv
// alsu_flag_gen: combinational Z/N/C status from ALSU result, carry-out and op group
module alsu_flag_gen
  import alsu_pkg::*;
(
  input  logic [W-1:0] f,
  input  logic         cout,
  input  logic [1:0]   grp,
  output logic         z,
  output logic         n,
  output logic         c
);
  always_comb begin
    z = (f == '0);
    n = f[W-1];
    c = (grp == LOGIC) ? 1'b0 : cout;
  end
endmodule

// File: rtl/alsu_acc_ctrl.sv
// alsu_acc_ctrl: accumulator/FSM driving an external ALSU; ALSU_ACC_STICKY_OVF_EN makes flag_v sticky across passes
module alsu_acc_ctrl
  import alsu_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [3:0]   cmd_op,
  input  logic         cmd_cin,
  input  logic [W-1:0] cmd_b,
  input  logic [2:0]   cmd_cnt,
  input  logic         cmd_load,
  output logic [W-1:0] alsu_a,
  output logic [W-1:0] alsu_b,
  output logic         alsu_cin,
  output logic [3:0]   alsu_s,
  input  logic [W-1:0] alsu_f,
  input  logic         alsu_cout,
  input  logic         alsu_ovf,
  output logic [W-1:0] acc,
  output logic         flag_z,
  output logic         flag_n,
  output logic         flag_c,
  output logic         flag_v,
  output logic         rsp_valid,
  input  logic         rsp_ready
);
  state_t state, nxt;
  logic [3:0] op_r;
  logic [W-1:0] b_r;
  logic cin_r;
  logic [2:0] rem;
  logic fz, fn, fc;
  logic accept, exec;
  alsu_flag_gen u_flags (.f(alsu_f), .cout(alsu_cout), .grp(op_r[3:2]), .z(fz), .n(fn), .c(fc));
  always_comb begin
    accept = (state == IDLE) && cmd_valid;
    exec = (state == EXEC);
    nxt = accept ? (cmd_load ? DONE : EXEC) :
          (exec && rem == 3'd0) ? DONE :
          (state == DONE && rsp_ready) ? IDLE : state;
    cmd_ready = (state == IDLE);
    rsp_valid = (state == DONE);
    alsu_a = acc;
    alsu_b = exec ? b_r : '0;
    alsu_cin = exec && cin_r;
    alsu_s = exec ? op_r : 4'b0000;
  end
  // rem holds passes still to run after the current one, so P-1 is loaded at accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      acc <= '0;
      op_r <= '0;
      b_r <= '0;
      cin_r <= 1'b0;
      rem <= '0;
      flag_z <= 1'b0;
      flag_n <= 1'b0;
      flag_c <= 1'b0;
      flag_v <= 1'b0;
    end else begin
      state <= nxt;
      if (accept && cmd_load) begin
        acc <= cmd_b;
        flag_z <= (cmd_b == '0);
        flag_n <= cmd_b[W-1];
        flag_c <= 1'b0;
        flag_v <= 1'b0;
      end else if (accept) begin
        op_r <= cmd_op;
        b_r <= cmd_b;
        cin_r <= cmd_cin;
        rem <= cmd_op[3] ? cmd_cnt : 3'd0;
        flag_v <= 1'b0;
      end else if (exec) begin
        acc <= alsu_f;
        flag_z <= fz;
        flag_n <= fn;
        flag_c <= fc;
`ifdef ALSU_ACC_STICKY_OVF_EN
        flag_v <= flag_v | alsu_ovf;
`else
        flag_v <= alsu_ovf;
`endif
        if (rem != 3'd0) rem <= rem - 3'd1;
      end
    end
  end
endmodule

// File: doc/alsu_acc_ctrl.md
ALSU_ACC_CTRL -- requirements
Module: alsu_acc_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clk in 1, rising-edge clock; rst_n in 1, asynchronous active-low reset.
REQ-002 cmd_valid in 1: command offered. cmd_ready out 1: command accepted when both are high.
REQ-003 cmd_op in 4: ALSU select {s3,s2,s1,s0}. cmd_cin in 1: carry/serial-in. cmd_b in 8: B operand. cmd_cnt in 3: extra shift passes. cmd_load in 1: load the accumulator from cmd_b.
REQ-004 alsu_a out 8, alsu_b out 8, alsu_cin out 1, alsu_s out 4: drive the downstream combinational ALSU.
REQ-005 alsu_f in 8, alsu_cout in 1, alsu_ovf in 1: ALSU result returned in the same cycle.
REQ-006 acc out 8: accumulator. flag_z, flag_n, flag_c, flag_v out 1 each: status flags.
REQ-007 rsp_valid out 1, rsp_ready in 1: response handshake; acc and flags are valid while rsp_valid is high.

Function
REQ-008 The FSM SHALL have states IDLE, EXEC and DONE; cmd_ready SHALL equal (state==IDLE).
REQ-009 IDLE with cmd_valid=1 and cmd_load=1:
- acc<=cmd_b.
- flag_z/flag_n recomputed from cmd_b; flag_c and flag_v cleared.
- Next state DONE.
REQ-010 IDLE with cmd_valid=1 and cmd_load=0:
- Register op, b, cin and cmd_cnt.
- Pass count P = 1 when op[3]=0; P = cmd_cnt+1 (1..8) when op[3]=1.
- Next state EXEC.
REQ-011 EXEC, each cycle:
- Drive alsu_a=acc and the registered b, cin and op.
- acc<=alsu_f; flag_z=(alsu_f==0); flag_n=alsu_f[7].
- flag_c=alsu_cout for op[3:2]!=01, else 0.
- Decrement the remaining-pass count; after pass P, go to DONE.
REQ-012 DONE: rsp_valid=1 and acc/flags held stable until rsp_ready=1; on the handshake cycle, go to IDLE.
REQ-013 Latency: command accepted at edge T -> rsp_valid from cycle T+1 (load) or T+P+1 (operate).
REQ-014 rsp_ready asserted early (in IDLE or EXEC) SHALL have no effect.
REQ-015 cmd_valid outside IDLE SHALL be ignored, with no state change.
REQ-016 Back-to-back: a new command may be accepted in the cycle after the DONE handshake; the IDLE bubble is mandatory.
REQ-017 In IDLE and DONE, alsu_s SHALL be 0000 and alsu_b/alsu_cin SHALL be 0.
REQ-018 Width: all datapaths are 8 bits with no wrap beyond the ALSU result; pass-counter underflow is impossible by construction.

Reset
REQ-019 While rst_n=0:
- state=IDLE, acc=0, all flags 0, rsp_valid=0, cmd_ready=1.
- Pass counter and captured operands cleared.
REQ-020 Reset asserted mid-EXEC or mid-DONE SHALL abandon the command without producing a response.

Configuration
REQ-021 Macro ALSU_ACC_STICKY_OVF_EN: when defined, flag_v SHALL be the OR of alsu_ovf over all passes of one command (cleared at accept); when undefined, flag_v SHALL be alsu_ovf from the final pass only.

Structure
REQ-022 Package alsu_pkg SHALL hold:
- Data width constant 8.
- FSM state enum.
- Op-group constants ARITH=00, LOGIC=01, SHR=10, SHL=11 (op[3:2]).
REQ-023 One sub-module, alsu_flag_gen (combinational Z/N/C from result, carry and op group), SHALL be instantiated; the FSM, counter and registers stay in alsu_acc_ctrl.

Verification
REQ-024 The bench SHALL model the ALSU as a responder driving alsu_f/alsu_cout/alsu_ovf from alsu_a/alsu_s, and SHALL cover:
- Load: cmd_load=1, cmd_b=8'h80 -> one cycle later rsp_valid=1, acc=80, N=1, Z=0, C=0, V=0.
- Single arithmetic pass: op=0000, model returns f=00, cout=1 -> rsp_valid at T+2, acc=00, Z=1, C=1.
- Repeated shift: op=1100, cmd_cnt=3, model returns {a[6:0],0} with ovf=1 on pass 2 only -> 4 EXEC cycles, rsp_valid at T+5; V=1 with the macro defined, V=0 without.
- Backpressure: rsp_ready held low 6 cycles -> acc/flags stable, cmd_ready=0, a cmd_valid pulse is ignored.
- Reset mid-EXEC: rst_n low during pass 2 of 4 -> acc=0, flags=0, rsp_valid never asserted, cmd_ready=1.
- Logic op: op=0110, model returns cout=1 -> C=0.
